// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts one bubble per load-use hazard and counts bubbles (saturating).
module id_ex_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm_ext,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic [3:0]       id_alu_op,
    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_rs_data,
    output logic [31:0]      ex_rt_data,
    output logic [31:0]      ex_imm_ext,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_alu_src,
    output logic             ex_reg_dst,
    output logic [3:0]       ex_alu_op,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } data_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [3:0] alu_op;
    } ctrl_t;

    data_t            data_q;
    data_t            data_d;
    data_t            id_data;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;
    ctrl_t            id_ctrl;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load_use;
    logic             rt_hit;
    logic             cnt_sat;

    // Gather the decode-side fields into bundles; an empty ID slot carries no controls.
    always_comb begin
        id_data         = '0;
        id_data.pc      = id_pc;
        id_data.rs_data = id_rs_data;
        id_data.rt_data = id_rt_data;
        id_data.imm_ext = id_imm_ext;
        id_data.rs      = id_rs;
        id_data.rt      = id_rt;
        id_data.rd      = id_rd;

        id_ctrl = '0;
        if (id_valid) begin
            id_ctrl.valid      = 1'b1;
            id_ctrl.reg_write  = id_reg_write;
            id_ctrl.mem_read   = id_mem_read;
            id_ctrl.mem_write  = id_mem_write;
            id_ctrl.mem_to_reg = id_mem_to_reg;
            id_ctrl.alu_src    = id_alu_src;
            id_ctrl.reg_dst    = id_reg_dst;
            id_ctrl.alu_op     = id_alu_op;
        end
    end

    // Load in EX whose destination is a source of the instruction in ID.
    always_comb begin
        rt_hit   = (data_q.rt == id_rs) | (data_q.rt == id_rt);
        load_use = ctrl_q.valid & ctrl_q.mem_read & id_valid
                 & (data_q.rt != 5'd0) & rt_hit;
    end

    assign hazard_stall = load_use & ~flush & ~stall;
    assign cnt_sat      = &cnt_q;

    // Next-state selection: flush beats stall beats hazard beats capture.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;
        if (flush) begin
            data_d = '0;
            ctrl_d = '0;
        end else if (stall) begin
            data_d = data_q;
            ctrl_d = ctrl_q;
        end else if (load_use) begin
            data_d = '0;
            ctrl_d = '0;
            if (!cnt_sat) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            data_d = id_data;
            ctrl_d = id_ctrl;
        end
    end

    // Pipeline register and bubble counter, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            ctrl_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_pc         = data_q.pc;
    assign ex_rs_data    = data_q.rs_data;
    assign ex_rt_data    = data_q.rt_data;
    assign ex_imm_ext    = data_q.imm_ext;
    assign ex_rs         = data_q.rs;
    assign ex_rt         = data_q.rt;
    assign ex_rd         = data_q.rd;
    assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios plus random traffic
// checked against a transaction-level model of the EX slot.
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        asrc;
        logic        rdst;
        logic [3:0]  op;
    } ins_t;

    logic clk = 1'b0;
    logic rst, stall, flush;
    ins_t id;

    logic        ex_valid, ex_rw, ex_mr, ex_mw, ex_m2r, ex_asrc, ex_rdst;
    logic [31:0] ex_pc, ex_rsd, ex_rtd, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [3:0]  ex_op;
    logic        hz;
    logic [15:0] cnt;

    logic        b_valid, b_rw, b_mr, b_mw, b_m2r, b_asrc, b_rdst;
    logic [31:0] b_pc, b_rsd, b_rtd, b_imm;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [3:0]  b_op;
    logic        b_hz;
    logic [1:0]  b_cnt;

    int   n_tests = 0;
    int   n_fail = 0;

    ins_t m_ex;
    bit   m_dc;
    bit   m_init = 0;
    int   m_cnt16;
    int   m_cnt2;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id.valid), .id_pc(id.pc), .id_rs_data(id.rsd),
        .id_rt_data(id.rtd), .id_imm_ext(id.imm), .id_rs(id.rs),
        .id_rt(id.rt), .id_rd(id.rd), .id_reg_write(id.rw),
        .id_mem_read(id.mr), .id_mem_write(id.mw),
        .id_mem_to_reg(id.m2r), .id_alu_src(id.asrc),
        .id_reg_dst(id.rdst), .id_alu_op(id.op),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rsd),
        .ex_rt_data(ex_rtd), .ex_imm_ext(ex_imm), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_rw),
        .ex_mem_read(ex_mr), .ex_mem_write(ex_mw),
        .ex_mem_to_reg(ex_m2r), .ex_alu_src(ex_asrc),
        .ex_reg_dst(ex_rdst), .ex_alu_op(ex_op),
        .hazard_stall(hz), .bubble_count(cnt)
    );

    id_ex_reg #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id.valid), .id_pc(id.pc), .id_rs_data(id.rsd),
        .id_rt_data(id.rtd), .id_imm_ext(id.imm), .id_rs(id.rs),
        .id_rt(id.rt), .id_rd(id.rd), .id_reg_write(id.rw),
        .id_mem_read(id.mr), .id_mem_write(id.mw),
        .id_mem_to_reg(id.m2r), .id_alu_src(id.asrc),
        .id_reg_dst(id.rdst), .id_alu_op(id.op),
        .ex_valid(b_valid), .ex_pc(b_pc), .ex_rs_data(b_rsd),
        .ex_rt_data(b_rtd), .ex_imm_ext(b_imm), .ex_rs(b_rs),
        .ex_rt(b_rt), .ex_rd(b_rd), .ex_reg_write(b_rw),
        .ex_mem_read(b_mr), .ex_mem_write(b_mw),
        .ex_mem_to_reg(b_m2r), .ex_alu_src(b_asrc),
        .ex_reg_dst(b_rdst), .ex_alu_op(b_op),
        .hazard_stall(b_hz), .bubble_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_hazard();
        return m_ex.valid && m_ex.mr && id.valid && m_ex.rt != 5'd0
            && (m_ex.rt == id.rs || m_ex.rt == id.rt);
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        bit h;
        h = model_hazard();
        if (rst) begin
            m_ex = '0; m_dc = 0; m_cnt16 = 0; m_cnt2 = 0; m_init = 1;
        end else if (flush) begin
            m_ex = '0; m_dc = 0;
        end else if (stall) begin
            m_ex = m_ex;
        end else if (h) begin
            m_ex = '0; m_dc = 0;
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end else begin
            m_ex = id;
            m_dc = !id.valid;
            if (!id.valid) begin
                m_ex.rw = 0; m_ex.mr = 0; m_ex.mw = 0; m_ex.m2r = 0;
                m_ex.asrc = 0; m_ex.rdst = 0; m_ex.op = '0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid", ex_valid, m_ex.valid);
        chk("reg_write", ex_rw, m_ex.rw);
        chk("mem_read", ex_mr, m_ex.mr);
        chk("mem_write", ex_mw, m_ex.mw);
        chk("mem_to_reg", ex_m2r, m_ex.m2r);
        chk("alu_src", ex_asrc, m_ex.asrc);
        chk("reg_dst", ex_rdst, m_ex.rdst);
        chk("alu_op", ex_op, m_ex.op);
        chk("bubbles", cnt, m_cnt16);
        chk("bubbles_small", b_cnt, m_cnt2);
        chk("small_valid", b_valid, m_ex.valid);
        if (!m_dc) begin
            chk("pc", ex_pc, m_ex.pc);
            chk("rs_data", ex_rsd, m_ex.rsd);
            chk("rt_data", ex_rtd, m_ex.rtd);
            chk("imm", ex_imm, m_ex.imm);
            chk("rs", ex_rs, m_ex.rs);
            chk("rt", ex_rt, m_ex.rt);
            chk("rd", ex_rd, m_ex.rd);
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick();
        #2;
        if (m_init)
            chk("hazard_stall", hz, model_hazard() && !flush && !stall);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    function automatic ins_t rand_ins();
        ins_t r;
        r.valid = ($urandom_range(0, 9) != 0);
        r.pc = $urandom; r.rsd = $urandom; r.rtd = $urandom;
        r.imm = $urandom;
        r.rs = 5'($urandom_range(0, 3));
        r.rt = 5'($urandom_range(0, 3));
        r.rd = 5'($urandom);
        r.rw = 1'($urandom); r.mr = 1'($urandom); r.mw = 1'($urandom);
        r.m2r = 1'($urandom); r.asrc = 1'($urandom);
        r.rdst = 1'($urandom); r.op = 4'($urandom);
        return r;
    endfunction

    function automatic ins_t lw(input logic [4:0] rt);
        ins_t r = '0;
        r.valid = 1; r.mr = 1; r.rw = 1; r.m2r = 1; r.asrc = 1;
        r.rt = rt; r.rs = 5'd9; r.pc = 32'h100; r.op = 4'd2;
        return r;
    endfunction

    function automatic ins_t add(input logic [4:0] rs);
        ins_t r = '0;
        r.valid = 1; r.rw = 1; r.rdst = 1; r.rs = rs; r.rt = 5'd7;
        r.rd = 5'd8; r.pc = 32'h104; r.op = 4'd1;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1; id = '0; stall = 0; flush = 0;
        tick();
        rst = 0;
    endtask

    initial begin
        ins_t held;
        rst = 0; stall = 0; flush = 0; id = '0;
        @(negedge clk);
        do_reset();
        chk("rst_valid", ex_valid, 0);
        chk("rst_count", cnt, 0);
        chk("rst_hz", hz, 0);

        id = '0; id.valid = 1; id.pc = 32'h8; id.imm = 32'hFFFF_FFFC;
        id.asrc = 1;
        tick();
        chk("basic_pc", ex_pc, 32'h8);
        chk("basic_imm", ex_imm, 32'hFFFF_FFFC);
        chk("basic_asrc", ex_asrc, 1);
        chk("basic_valid", ex_valid, 1);

        do_reset();
        id = lw(5'd5); tick();
        id = add(5'd5); #1 chk("lu_hz", hz, 1);
        tick();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_mr", ex_mr, 0);
        chk("lu_count", cnt, 1);
        chk("lu_hz_after", hz, 0);
        tick();
        chk("lu_cap_pc", ex_pc, 32'h104);
        chk("lu_cap_valid", ex_valid, 1);

        do_reset();
        id = lw(5'd0); tick();
        id = add(5'd0); #1 chk("r0_hz", hz, 0);
        tick();
        chk("r0_valid", ex_valid, 1);
        chk("r0_pc", ex_pc, 32'h104);
        chk("r0_count", cnt, 0);

        id = add(5'd3); id.pc = 32'h200; tick();
        held = id;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id = rand_ins(); id.pc = 32'h300 + 32'(i);
            tick();
            chk("stall_pc", ex_pc, held.pc);
        end
        stall = 0; id = rand_ins(); id.valid = 1; id.pc = 32'h400;
        tick();
        chk("unstall_pc", ex_pc, 32'h400);

        do_reset();
        id = lw(5'd5); tick();
        id = add(5'd5); flush = 1; #1 chk("fl_hz", hz, 0);
        tick();
        flush = 0;
        chk("fl_valid", ex_valid, 0);
        chk("fl_rw", ex_rw, 0);
        chk("fl_mr", ex_mr, 0);
        chk("fl_count", cnt, 0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            id = lw(5'd4); tick();
            id = add(5'd4); tick();
            tick();
        end
        chk("sat_small", b_cnt, 2'd3);
        chk("sat_wide", cnt, 5);
        rst = 1; id = lw(5'd4); tick(); rst = 0;
        chk("sat_rst", b_cnt, 0);
        chk("sat_rst_valid", b_valid, 0);
        chk("sat_rst_pc", b_pc, 0);

        for (int i = 0; i < 600; i++) begin
            id = rand_ins();
            rst = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 6) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter CNT_W, default 16, width of the load-use bubble counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  downstream (EX/MEM) hold request; register keeps contents.
REQ-005 flush  input  1  branch/jump squash; next captured stage is a bubble.
REQ-006 id_valid  input  1  decode stage holds a real instruction.
REQ-007 id_pc  input  32  PC+4 of decoded instruction.
REQ-008 id_rs_data, id_rt_data  input  32 each  register file read data.
REQ-009 id_imm_ext  input  32  sign-extended immediate from the sign-extension unit.
REQ-010 id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-011 id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  input  1 each  decode control bits.
REQ-012 id_alu_op  input  4  ALU operation select.
REQ-013 ex_* outputs  output  widths equal to matching id_* inputs  registered copies of all REQ-007..REQ-012 fields.
REQ-014 ex_valid  output  1  EX stage holds a real instruction.
REQ-015 hazard_stall  output  1  load-use hazard; IF/ID and PC must hold this cycle.
REQ-016 bubble_count  output  CNT_W  number of load-use bubbles inserted since reset.

Function
REQ-017 load_use (combinational) = ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-018 hazard_stall = load_use & ~flush & ~stall; depends only on registered ex_* state and id_* inputs, no clock delay.
REQ-019 Update priority per edge: rst > flush > stall > load_use > normal capture.
REQ-020 flush: ex_valid <= 0; all ex_* control bits and ex_alu_op <= 0; data/specifier fields <= 0.
REQ-021 stall (no flush): every output register holds its value; bubble_count holds.
REQ-022 load_use (no flush, no stall): bubble inserted exactly as REQ-020; bubble_count increments by 1.
REQ-023 Normal capture: all ex_* <= id_*; ex_valid <= id_valid.
REQ-024 id_valid = 0 on normal capture: ex_valid <= 0 and all ex_* control bits <= 0; data fields may be captured as-is.
REQ-025 ex_imm_ext is passed bit-for-bit; no re-extension or truncation.
REQ-026 Latency: one clock from id_* to ex_*; a stalled instruction reaches EX the first unstalled, unflushed edge.
REQ-027 bubble_count saturates at all-ones; no wrap.
REQ-028 Load-use check always compares against the instruction currently in EX, so a hazard produces exactly one bubble; the following edge captures the held ID instruction.
REQ-029 Simultaneous flush and load_use: flush wins, hazard_stall = 0, bubble_count unchanged.

Reset
REQ-030 On rst at a rising edge: all ex_* = 0, ex_valid = 0, bubble_count = 0; hazard_stall = 0 in the following cycle.
REQ-031 rst asserted mid-stall or mid-hazard overrides both; no state from before reset is visible after it.
REQ-032 Outputs are undefined before the first reset edge; no asynchronous path from rst.

Verification
REQ-033 Reset, then id_valid=1, id_pc=0x00000008, id_imm_ext=0xFFFFFFFC, id_alu_src=1 -> after one edge ex_pc=0x00000008, ex_imm_ext=0xFFFFFFFC, ex_alu_src=1, ex_valid=1.
REQ-034 EX holds lw with ex_rt=5; ID presents add id_rs=5 -> hazard_stall=1 same cycle; next edge ex_valid=0, ex_mem_read=0, bubble_count=1; following edge captures add, hazard_stall=0.
REQ-035 Same hazard with ex_rt=0 (id_rs=0) -> hazard_stall=0, instruction captured normally, bubble_count=0.
REQ-036 stall=1 for 3 cycles while id_* changes each cycle -> ex_* unchanged all 3 edges; after stall drops, next edge captures current id_*.
REQ-037 flush=1 together with a load-use hazard -> hazard_stall=0, next edge ex_valid=0, all controls 0, bubble_count unchanged.
REQ-038 Force bubble_count to all-ones via CNT_W=2 and 4 hazards -> count reads 3 and stays 3; then rst -> all outputs 0.
